// File: rtl/mem_defs.sv
// Shared definitions for the Ram2 SRAM controller: FSM states, RAM-select codes, default geometry.
// Optional store-to-load forwarding in the controller is enabled by RAM2_WRITE_FWD_EN.
package mem_defs;

    localparam int ADDR_W_DEF      = 18;
    localparam int DATA_W_DEF      = 16;
    localparam int WAIT_CYCLES_DEF = 1;
    localparam int CNT_W           = 3;

    localparam logic RAM_SEL_RAM1 = 1'b0;
    localparam logic RAM_SEL_RAM2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram2_wait_counter.sv
// Loadable down-counter timing SRAM read sample and write pulse; saturates at zero.
// zero flags the decrement that takes the count from 1 to 0 (last wait cycle).
module ram2_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = dec && (cnt == W'(1));

endmodule

// File: rtl/ram2_mem_ctrl.sv
// Ram2 SRAM bus controller: read 2+WAIT_CYCLES, write 3+WAIT_CYCLES cycles from accept to resp_valid.
// Stalls the pipeline while an access is in flight. RAM2_WRITE_FWD_EN adds a 1-entry last-write bypass.
module ram2_mem_ctrl
    import mem_defs::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              addr_src,
    input  logic [15:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              resp_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] ram2_addr,
    output logic [DATA_W-1:0] ram2_dout,
    input  logic [DATA_W-1:0] ram2_din,
    output logic              ram2_doe,
    output logic              ram2_en_n,
    output logic              ram2_oe_n,
    output logic              ram2_we_n
);

    state_t            state, nstate;
    logic [15:0]       addr_q;
    logic              accept, latch, rd_capture, cnt_load, cnt_dec, cnt_zero;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_dat;

    assign accept    = (addr_src == RAM_SEL_RAM2) && (mem_read || mem_write);
    assign ram2_addr = {{(ADDR_W-16){1'b0}}, addr_q};

`ifdef RAM2_WRITE_FWD_EN
    logic        fwd_vld;
    logic [15:0] fwd_addr;

    // Entry captures the write as it retires, so it always mirrors SRAM contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_dat  <= '0;
        end else if (state == ST_WR_HOLD) begin
            fwd_vld  <= 1'b1;
            fwd_addr <= addr_q;
            fwd_dat  <= ram2_dout;
        end
    end

    assign fwd_hit = fwd_vld && (fwd_addr == address);
`else
    assign fwd_hit = 1'b0;
    assign fwd_dat = '0;
`endif

    ram2_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate     = state;
        stall      = 1'b0;
        resp_valid = 1'b0;
        ram2_en_n  = 1'b1;
        ram2_oe_n  = 1'b1;
        ram2_we_n  = 1'b1;
        ram2_doe   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        latch      = 1'b0;
        rd_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (mem_read && fwd_hit) begin
                        nstate = ST_DONE;
                    end else begin
                        latch  = 1'b1;
                        stall  = 1'b1;
                        nstate = mem_read ? ST_RD_SETUP : ST_WR_SETUP;
                    end
                end
            end
            ST_RD_SETUP: begin
                stall     = 1'b1;
                ram2_en_n = 1'b0;
                ram2_oe_n = 1'b0;
                cnt_load  = 1'b1;
                nstate    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                stall     = 1'b1;
                ram2_en_n = 1'b0;
                ram2_oe_n = 1'b0;
                cnt_dec   = 1'b1;
                if (cnt_zero) begin
                    rd_capture = 1'b1;
                    nstate     = ST_DONE;
                end
            end
            ST_WR_SETUP: begin
                stall     = 1'b1;
                ram2_en_n = 1'b0;
                ram2_doe  = 1'b1;
                cnt_load  = 1'b1;
                nstate    = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                stall     = 1'b1;
                ram2_en_n = 1'b0;
                ram2_we_n = 1'b0;
                ram2_doe  = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt_zero) begin
                    nstate = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                stall     = 1'b1;
                ram2_en_n = 1'b0;
                ram2_doe  = 1'b1;
                nstate    = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                nstate     = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            ram2_dout <= '0;
            read_data <= '0;
        end else begin
            if (latch) begin
                addr_q    <= address;
                ram2_dout <= write_data;
            end
            if (rd_capture) begin
                read_data <= ram2_din;
            end else if (state == ST_IDLE && accept && mem_read && fwd_hit) begin
                read_data <= fwd_dat;
            end
        end
    end

endmodule

// File: tb/tb_ram2_mem_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=1 and 3) on shared request inputs, each with its own SRAM model.
module tb_ram2_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, addr_src;
    logic [15:0] address, write_data;

    logic [15:0] a_rd, a_dout, a_din, b_rd, b_dout, b_din;
    logic [17:0] a_addr, b_addr;
    logic        a_resp, a_stall, a_doe, a_en, a_oe, a_we;
    logic        b_resp, b_stall, b_doe, b_en, b_oe, b_we;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int npass = 0, ntotal = 0;
    int resp_cyc[2], we_cnt[2], oe_cnt[2], en_cnt[2], stall_cnt[2], resp_cnt[2], doe_cnt[2], clash[2];
    logic [17:0] last_addr[2];
    int strobe_lo;

    always #5 clk = ~clk;

    ram2_mem_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src),
        .address(address), .write_data(write_data), .read_data(a_rd), .resp_valid(a_resp),
        .stall(a_stall), .ram2_addr(a_addr), .ram2_dout(a_dout), .ram2_din(a_din),
        .ram2_doe(a_doe), .ram2_en_n(a_en), .ram2_oe_n(a_oe), .ram2_we_n(a_we)
    );

    ram2_mem_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src),
        .address(address), .write_data(write_data), .read_data(b_rd), .resp_valid(b_resp),
        .stall(b_stall), .ram2_addr(b_addr), .ram2_dout(b_dout), .ram2_din(b_din),
        .ram2_doe(b_doe), .ram2_en_n(b_en), .ram2_oe_n(b_oe), .ram2_we_n(b_we)
    );

    assign a_din = (!a_en && !a_oe) ? mem_a[a_addr[7:0]] : 16'hDEAD;
    assign b_din = (!b_en && !b_oe) ? mem_b[b_addr[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!a_en && !a_we) mem_a[a_addr[7:0]] <= a_dout;
        if (!b_en && !b_we) mem_b[b_addr[7:0]] <= b_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sample_cycle(input int c);
        if (!a_we) we_cnt[0]++;
        if (!a_oe) oe_cnt[0]++;
        if (!a_en) begin en_cnt[0]++; last_addr[0] = a_addr; end
        if (a_stall) stall_cnt[0]++;
        if (a_doe) doe_cnt[0]++;
        if (!a_we && !a_oe) clash[0]++;
        if (a_resp) begin resp_cnt[0]++; if (resp_cyc[0] < 0) resp_cyc[0] = c; end
        if (!b_we) we_cnt[1]++;
        if (!b_oe) oe_cnt[1]++;
        if (!b_en) begin en_cnt[1]++; last_addr[1] = b_addr; end
        if (b_stall) stall_cnt[1]++;
        if (b_doe) doe_cnt[1]++;
        if (!b_we && !b_oe) clash[1]++;
        if (b_resp) begin resp_cnt[1]++; if (resp_cyc[1] < 0) resp_cyc[1] = c; end
    endtask

    // Cycle 0 is the cycle the request is presented; the request is dropped from cycle 1 on.
    task automatic observe(input int n);
        for (int d = 0; d < 2; d++) begin
            resp_cyc[d] = -1; we_cnt[d] = 0; oe_cnt[d] = 0; en_cnt[d] = 0;
            stall_cnt[d] = 0; resp_cnt[d] = 0; doe_cnt[d] = 0; clash[d] = 0; last_addr[d] = '1;
        end
        sample_cycle(0);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin mem_read = 1'b0; mem_write = 1'b0; addr_src = 1'b0; end
            #1;
            sample_cycle(c);
        end
    endtask

    task automatic request(input logic rd, input logic wr, input logic sel,
                           input logic [15:0] ad, input logic [15:0] wd);
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr_src = sel; address = ad; write_data = wd;
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr_src = 1'b0;
        address = '0; write_data = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        mem_a[8'h34] = 16'h1234;
        mem_b[8'h34] = 16'h1234;
        #12;

        chk("rst_read_data", a_rd, 0);
        chk("rst_resp", a_resp, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_doe", a_doe, 0);
        chk("rst_strobes", {a_en, a_oe, a_we, b_en, b_oe, b_we}, 6'b111111);

        @(negedge clk) rst = 1'b1;
        strobe_lo = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!(a_en && a_oe && a_we && b_en && b_oe && b_we) || a_stall || a_resp) strobe_lo++;
        end
        chk("idle_10_cycles_quiet", strobe_lo, 0);

        // Write 0xA5A5 to 0x0012
        request(1'b0, 1'b1, 1'b1, 16'h0012, 16'hA5A5);
        chk("wr_accept_stall", {a_stall, b_stall}, 2'b11);
        observe(10);
        chk("wr_we_pulse_w1", we_cnt[0], 1);
        chk("wr_we_pulse_w3", we_cnt[1], 3);
        chk("wr_stall_cycles_w1", stall_cnt[0], 4);
        chk("wr_stall_cycles_w3", stall_cnt[1], 6);
        chk("wr_latency_w1", resp_cyc[0], 4);
        chk("wr_latency_w3", resp_cyc[1], 6);
        chk("wr_resp_once", resp_cnt[0] + resp_cnt[1], 2);
        chk("wr_bus_addr", last_addr[0], 18'h00012);
        chk("wr_doe_cycles_w1", doe_cnt[0], 3);
        chk("wr_oe_never_low", oe_cnt[0] + oe_cnt[1], 0);
        chk("wr_sram_data_w1", mem_a[8'h12], 16'hA5A5);
        chk("wr_sram_data_w3", mem_b[8'h12], 16'hA5A5);

        // Read back the just-written address
        request(1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000);
        observe(8);
`ifdef RAM2_WRITE_FWD_EN
        chk("rd_hit_latency_w1", resp_cyc[0], 1);
        chk("rd_hit_latency_w3", resp_cyc[1], 1);
        chk("rd_hit_no_bus", en_cnt[0] + en_cnt[1], 0);
        chk("rd_hit_no_stall", stall_cnt[0] + stall_cnt[1], 0);
`else
        chk("rd_latency_w1", resp_cyc[0], 3);
        chk("rd_latency_w3", resp_cyc[1], 5);
        chk("rd_en_cycles_w1", en_cnt[0], 2);
        chk("rd_en_cycles_w3", en_cnt[1], 4);
`endif
        chk("rd_data_w1", a_rd, 16'hA5A5);
        chk("rd_data_w3", b_rd, 16'hA5A5);

        // Read and write both high: read wins
        request(1'b1, 1'b1, 1'b1, 16'h0034, 16'hFFFF);
        observe(8);
        chk("both_latency_w1", resp_cyc[0], 3);
        chk("both_latency_w3", resp_cyc[1], 5);
        chk("both_we_never_low", we_cnt[0] + we_cnt[1], 0);
        chk("both_doe_never", doe_cnt[0] + doe_cnt[1], 0);
        chk("both_oe_cycles_w3", oe_cnt[1], 4);
        chk("both_no_clash", clash[0] + clash[1], 0);
        chk("both_data_w1", a_rd, 16'h1234);
        chk("both_data_w3", b_rd, 16'h1234);
        chk("both_sram_untouched", mem_a[8'h34], 16'h1234);

        // Not targeted at Ram2
        request(1'b0, 1'b1, 1'b0, 16'h0050, 16'h5555);
        chk("sel0_stall", {a_stall, b_stall}, 2'b00);
        observe(6);
        chk("sel0_no_bus", en_cnt[0] + en_cnt[1], 0);
        chk("sel0_no_resp", resp_cnt[0] + resp_cnt[1], 0);
        chk("sel0_read_data_held", a_rd, 16'h1234);

        // Reset during the write pulse
        request(1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
        @(negedge clk); mem_write = 1'b0; addr_src = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_in_pulse", {a_we, b_we}, 2'b00);
        rst = 1'b0;
        #1;
        chk("rstmid_we_high", {a_we, b_we}, 2'b11);
        chk("rstmid_doe_low", {a_doe, b_doe}, 2'b00);
        chk("rstmid_en_high", {a_en, b_en}, 2'b11);
        chk("rstmid_addr_clr", a_addr, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        observe(6);
        chk("rstmid_no_resp", resp_cnt[0] + resp_cnt[1], 0);
        chk("rstmid_no_bus", en_cnt[0] + en_cnt[1], 0);

        // Controller is back in IDLE and serves a fresh read from the bus
        request(1'b1, 1'b0, 1'b1, 16'h0034, 16'h0000);
        observe(8);
        chk("post_rst_latency_w1", resp_cyc[0], 3);
        chk("post_rst_latency_w3", resp_cyc[1], 5);
        chk("post_rst_data", b_rd, 16'h1234);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
